// File: rtl/pitch_pkg.sv
// -----------------------------------------------------------------------------
// pitch_pkg
// Shared types for the pitch-detection slice.
//   zc_state_e : zero-crossing tracker FSM states. ACQ_* states hunt for the
//                first low-then-high sequence; TRK_* states measure periods.
// -----------------------------------------------------------------------------
package pitch_pkg;

    typedef enum logic [1:0] {
        ACQ_HIGH = 2'd0,
        ACQ_LOW  = 2'd1,
        TRK_LOW  = 2'd2,
        TRK_HIGH = 2'd3
    } zc_state_e;

endpackage

// File: rtl/schmitt_trigger.sv
// -----------------------------------------------------------------------------
// schmitt_trigger
// Symmetric Schmitt comparator on a signed sample stream. The level only
// moves on accepted samples at or beyond +/-HYST; samples strictly inside the
// band leave it untouched.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (level resets high)
//   accept      : strobe, x_data is a consumed sample this cycle
//   x_data      : signed W-bit sample
//   rise_event  : accepted sample >= +HYST while the level is low
//   fall_event  : accepted sample <= -HYST (regardless of current level)
//   level       : registered Schmitt level (1 = high)
// -----------------------------------------------------------------------------
module schmitt_trigger #(
    parameter int W    = 16,
    parameter int HYST = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                accept,
    input  logic signed [W-1:0] x_data,
    output logic                rise_event,
    output logic                fall_event,
    output logic                level
);

    localparam logic signed [W-1:0] POS_TH = W'(HYST);
    localparam logic signed [W-1:0] NEG_TH = -POS_TH;

    logic hi_hit;
    logic lo_hit;

    assign hi_hit = (x_data >= POS_TH);
    assign lo_hit = (x_data <= NEG_TH);

    assign rise_event = accept && hi_hit && !level;
    assign fall_event = accept && lo_hit;

    // Reset high so the ACQ_HIGH start state and the level agree.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= 1'b1;
        end else if (accept) begin
            if (hi_hit) begin
                level <= 1'b1;
            end else if (lo_hit) begin
                level <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/zero_cross_period.sv
// -----------------------------------------------------------------------------
// zero_cross_period
// Measures the period, in samples, between consecutive rising Schmitt
// crossings of a decimated signed sample stream and streams it out.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   x_valid/x_ready/x_data      : input sample stream (signed W bits)
//   period_valid/period_ready/
//   period_data                 : measured period stream (CNT_W bits)
//   locked                      : high while the FSM is in a TRK state
// Periods outside [MIN_PERIOD, MAX_PERIOD] are dropped; a run of MAX_PERIOD
// samples without a rising crossing drops the tracker back to acquisition.
// -----------------------------------------------------------------------------
module zero_cross_period
    import pitch_pkg::*;
#(
    parameter int W          = 16,
    parameter int CNT_W      = 12,
    parameter int HYST       = 64,
    parameter int MIN_PERIOD = 8,
    parameter int MAX_PERIOD = 2000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                x_valid,
    output logic                x_ready,
    input  logic signed [W-1:0] x_data,
    output logic                period_valid,
    input  logic                period_ready,
    output logic [CNT_W-1:0]    period_data,
    output logic                locked
);

    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MAX_P    = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_PERIOD - 1);

    zc_state_e        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] period;
    logic             emit;
    logic             accept;
    logic             rise_event;
    logic             fall_event;
    logic             level;

    // A sample is only taken when the output register can absorb a result.
    assign x_ready = !period_valid || period_ready;
    assign accept  = x_valid && x_ready;
    assign locked  = (state == TRK_LOW) || (state == TRK_HIGH);
    assign period  = cnt + CNT_W'(1);

    schmitt_trigger #(
        .W    (W),
        .HYST (HYST)
    ) u_schmitt (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept),
        .x_data     (x_data),
        .rise_event (rise_event),
        .fall_event (fall_event),
        .level      (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACQ_HIGH;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        emit    = 1'b0;
        if (accept) begin
            unique case (state)
                ACQ_HIGH: begin
                    // Raw threshold, not an edge: a timeout taken on the
                    // falling sample can leave the Schmitt level already low.
                    if (fall_event) begin
                        state_d = ACQ_LOW;
                    end
                end
                ACQ_LOW: begin
                    if (rise_event) begin
                        state_d = TRK_HIGH;
                        cnt_d   = '0;
                    end
                end
                TRK_HIGH, TRK_LOW: begin
                    if (state == TRK_LOW && rise_event) begin
                        state_d = TRK_HIGH;
                        cnt_d   = '0;
                        emit    = (period >= MIN_P) && (period <= MAX_P);
                    end else if (cnt == MAX_LAST) begin
                        // Timeout fires before the counter could wrap.
                        cnt_d   = '0;
                        state_d = (state == TRK_HIGH) ? ACQ_HIGH : ACQ_LOW;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                        if (state == TRK_HIGH && fall_event && level) begin
                            state_d = TRK_LOW;
                        end
                    end
                end
                default: state_d = ACQ_HIGH;
            endcase
        end
    end

    // Single output register; a new period wins over a same-edge handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_valid <= 1'b0;
            period_data  <= '0;
        end else if (emit) begin
            period_valid <= 1'b1;
            period_data  <= period;
        end else if (period_valid && period_ready) begin
            period_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zero_cross_period.sv
// -----------------------------------------------------------------------------
// tb_zero_cross_period
// Directed scenarios with hand-computed periods. The stimulus side pushes the
// expected period when it sends the rising sample that should produce it; an
// independent monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_zero_cross_period;
    import pitch_pkg::*;

    localparam int W     = 16;
    localparam int CNT_W = 12;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                x_valid = 1'b0;
    logic                x_ready;
    logic signed [W-1:0] x_data = '0;
    logic                period_valid;
    logic                period_ready = 1'b1;
    logic [CNT_W-1:0]    period_data;
    logic                locked;

    int compared   = 0;
    int mismatched = 0;
    int n_out      = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    zero_cross_period #(
        .W          (W),
        .CNT_W      (CNT_W),
        .HYST       (64),
        .MIN_PERIOD (8),
        .MAX_PERIOD (2000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_data       (x_data),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .period_data  (period_data),
        .locked       (locked)
    );

    function automatic void check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares every handshaken output against the scoreboard.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!reset && period_valid && period_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_output: got %0d, required none (t=%0t)",
                             period_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("period_data", int'(period_data), e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the sample is accepted.
    task automatic send(input int v);
        int waits = 0;
        x_valid = 1'b1;
        x_data  = W'(v);
        @(negedge clk);
        while (!x_ready && waits < 1000) begin
            waits++;
            @(negedge clk);
        end
        if (!x_ready) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: got x_ready=0, required 1 (t=%0t)", $time);
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    // Square wave +/-1000, high half first. Expect period p at the rising
    // sample of every cycle index >= first_out when want_out is set.
    task automatic square(input int p, input int ncyc, input int first_out, input bit want_out);
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < p; i++) begin
                if (i == 0 && c >= first_out && want_out) exp_q.push_back(p);
                send((i < p / 2) ? 1000 : -1000);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (!period_valid && n < limit) begin
            n++;
            @(negedge clk);
        end
        check(name, int'(period_valid), 1);
    endtask

    task automatic drain(input string name);
        idle(5);
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        x_valid      = 1'b0;
        period_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", int'(locked), 0);
        check("rst_valid", int'(period_valid), 0);
        check("rst_data", int'(period_data), 0);
        check("rst_state", int'(dut.state), int'(ACQ_HIGH));
        reset = 1'b0;
    endtask

    initial begin
        int n0;
        real pi = 3.14159265358979;

        // 1: square period 20, first output after the second rising edge.
        do_reset();
        square(20, 6, 2, 1'b1);
        check("sq20_locked", int'(locked), 1);
        drain("sq20_drain");

        // 2: sine below hysteresis never locks.
        do_reset();
        n0 = n_out;
        for (int i = 0; i < 200; i++) send(int'(50.0 * $sin(2.0 * pi * i / 32.0)));
        idle(3);
        check("sine_locked", int'(locked), 0);
        check("sine_outputs", n_out - n0, 0);

        // 3: period 6 is dropped; then exactly MIN_PERIOD (8) is reported.
        do_reset();
        n0 = n_out;
        square(6, 10, 2, 1'b0);
        idle(3);
        check("sq6_locked", int'(locked), 1);
        check("sq6_outputs", n_out - n0, 0);
        square(8, 4, 1, 1'b1);   // first rise closes a 6-sample period
        drain("sq8_drain");

        // 4: lock, timeout on a held high, then reacquire at period 40.
        do_reset();
        square(20, 4, 2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) exp_q.push_back(20);
            send(1000);
        end
        check("pre_hold_locked", int'(locked), 1);
        for (int i = 0; i < 2000; i++) send(1000);
        check("timeout_locked", int'(locked), 0);
        square(40, 4, 2, 1'b1);
        check("sq40_locked", int'(locked), 1);
        drain("sq40_drain");

        // 5: backpressure holds the output and stalls input.
        do_reset();
        fork
            square(20, 10, 2, 1'b1);
            begin
                wait_valid("bp_first_valid", 200);
                @(posedge clk);
                #1;
                period_ready = 1'b0;
                wait_valid("bp_stall_valid", 100);
                for (int i = 0; i < 100; i++) begin
                    check("bp_x_ready", int'(x_ready), 0);
                    check("bp_data", int'(period_data), 20);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                period_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // 6: asynchronous reset with a pending output.
        do_reset();
        period_ready = 1'b0;
        square(20, 2, 2, 1'b0);
        send(1000);              // rising sample loads period 20, not consumed
        check("pend_valid", int'(period_valid), 1);
        check("pend_x_ready", int'(x_ready), 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", int'(period_valid), 0);
        check("async_locked", int'(locked), 0);
        check("async_data", int'(period_data), 0);
        check("async_state", int'(dut.state), int'(ACQ_HIGH));
        @(posedge clk);
        #1;
        reset        = 1'b0;
        period_ready = 1'b1;
        n0 = n_out;
        square(20, 4, 2, 1'b1);
        drain("post_rst_drain");
        check("post_rst_outputs", n_out - n0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
